enabled_decoder_seq: RTL
========================

ENABLED_DECODER_SEQ -- requirements
Module: enabled_decoder_seq

Interface
REQ-001 SHALL have parameter SEL_W, default 3, select width; N = 2**SEL_W outputs; legal range 1..6.
REQ-002 SHALL have parameter SCAN_DIV, default 1, clock cycles per scan step; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  enable; 0 forces all outputs low on the next edge.
REQ-006 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-007 sel  input  SEL_W  direct-mode select; scan-mode load value.
REQ-008 load  input  1  scan mode: load sel into the scan index.
REQ-009 out  output  N  registered one-hot decode; all-zero when disabled.
REQ-010 idx  output  SEL_W  index currently driven on out.
REQ-011 wrap  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-012 FSM states: IDLE, DIRECT, SCAN; state is registered.
REQ-013 Transitions on each edge: en=0 -> IDLE; en=1 and mode=0 -> DIRECT; en=1 and mode=1 -> SCAN.
REQ-014 IDLE: out=0, wrap=0, idx holds its last value, divider count cleared.
REQ-015 DIRECT: out[sel]=1, all other bits 0; idx=sel; latency 1 clock from sel/en to out.
REQ-016 SCAN entry from IDLE or DIRECT: idx is unchanged; out=onehot(idx) on the entry edge.
REQ-017 SCAN: divider counts 0..SCAN_DIV-1; idx advances by 1 on the edge where the divider equals SCAN_DIV-1.
REQ-018 SCAN_DIV=1 advances idx every cycle.
REQ-019 idx arithmetic is modulo N: N-1 -> 0 sets wrap=1 for exactly that one cycle.
REQ-020 load=1 in SCAN: idx<=sel, divider<=0, wrap=0; load has priority over advance.
REQ-021 load is ignored in DIRECT and IDLE.
REQ-022 out SHALL never have more than one bit set; out is all-zero only in IDLE.
REQ-023 A mode change mid-scan takes effect on the next edge with no extra cycle; divider is cleared on leaving SCAN.
REQ-024 wrap is 0 in all states except SCAN.

Reset
REQ-025 reset_n=0 forces the following immediately, independent of clk: state=IDLE, out=0, idx=0, wrap=0, divider=0.
REQ-026 Reset assertion mid-scan aborts the scan; no wrap pulse is emitted.
REQ-027 Reset release is sampled on the first rising clk edge with reset_n=1.

Configuration
REQ-028 Macro ENABLED_DECODER_SEQ_DOWN_EN defined: adds input port dir (1 bit).
REQ-029 With the macro, dir=1 in SCAN decrements idx modulo N; wrap pulses on the 0 -> N-1 step.
REQ-030 With the macro, dir has no effect outside SCAN.
REQ-031 Macro undefined: dir port is absent and scan is up-count only.

Verification (SEL_W=3, SCAN_DIV=1 unless stated)
REQ-032 en=1, mode=0, sel swept 0..7 -> out=8'h01..8'h80, each one cycle after sel is applied; en=0 -> out=8'h00 next cycle.
REQ-033 en=1, mode=1 from idx=0 for 9 cycles -> idx=1,2..7,0,1; wrap=1 only in the cycle idx becomes 0.
REQ-034 SCAN_DIV=3, scan from idx=5 -> idx changes every 3rd edge: 6, 7, 0 (wrap), 1.
REQ-035 In SCAN at idx=2, load=1 with sel=6 -> idx=6, out=8'h40 next cycle; load asserted in the same cycle as an advance still yields 6.
REQ-036 reset_n=0 mid-scan at idx=4, asserted between clock edges -> out=0 and idx=0 immediately, with no clk edge; after release, en=1, mode=1 -> out=8'h01.
REQ-037 With ENABLED_DECODER_SEQ_DOWN_EN, dir=1 scan from idx=1 -> idx=0, 7 (wrap=1), 6.

Source files
------------

// File: rtl/enabled_decoder_seq_if.sv
// enabled_decoder_seq_if -- control/decode bundle for enabled_decoder_seq.
//   master : drives en, mode, sel, load (and dir when ENABLED_DECODER_SEQ_DOWN_EN
//            is defined); observes out, idx, wrap.
//   slave  : the decoder side of the same signals.
// The optional dir signal exists only when ENABLED_DECODER_SEQ_DOWN_EN is defined.
interface enabled_decoder_seq_if #(
  parameter int SEL_W = 3
);
  localparam int N = 2 ** SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic             load;
  logic [N-1:0]     out;
  logic [SEL_W-1:0] idx;
  logic             wrap;
`ifdef ENABLED_DECODER_SEQ_DOWN_EN
  logic             dir;

  modport master (output en, mode, sel, load, dir, input out, idx, wrap);
  modport slave  (input en, mode, sel, load, dir, output out, idx, wrap);
`else
  modport master (output en, mode, sel, load, input out, idx, wrap);
  modport slave  (input en, mode, sel, load, output out, idx, wrap);
`endif
endinterface

// File: rtl/enabled_decoder_seq.sv
// enabled_decoder_seq -- registered one-hot decoder with an auto-scan mode.
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : enabled_decoder_seq_if.slave
//             en/mode/sel/load (+dir) in; out (one-hot), idx, wrap out
// Parameters: SEL_W (1..6) select width, N = 2**SEL_W outputs;
//             SCAN_DIV (1..255) clocks per scan step.
// Optional feature: define ENABLED_DECODER_SEQ_DOWN_EN to add bus.dir,
// which makes the scan count down (modulo N) while dir=1.
module enabled_decoder_seq #(
  parameter int SEL_W    = 3,
  parameter int SCAN_DIV = 1
) (
  input logic              clk,
  input logic              reset_n,
  enabled_decoder_seq_if.slave bus
);
  localparam int N = 2 ** SEL_W;
  localparam logic [7:0] DIV_MAX = 8'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t           state;
  logic [N-1:0]     out_q;
  logic [SEL_W-1:0] idx_q;
  logic             wrap_q;
  logic [7:0]       div_q;

  logic [SEL_W-1:0] idx_step;   // idx after one scan step
  logic             at_edge;    // this step crosses the N-1 <-> 0 boundary

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    idx_step = idx_q + 1'b1;
    at_edge  = (idx_q == SEL_W'(N - 1));
`ifdef ENABLED_DECODER_SEQ_DOWN_EN
    if (bus.dir) begin
      idx_step = idx_q - 1'b1;
      at_edge  = (idx_q == '0);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      out_q  <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      div_q  <= '0;
    end else begin
      wrap_q <= 1'b0;
      if (!bus.en) begin
        // idx deliberately holds so a later scan resumes where it was
        state <= IDLE;
        out_q <= '0;
        div_q <= '0;
      end else if (!bus.mode) begin
        state <= DIRECT;
        idx_q <= bus.sel;
        out_q <= onehot(bus.sel);
        div_q <= '0;
      end else if (state != SCAN) begin
        // entry edge: show the current idx, start a fresh divider period
        state <= SCAN;
        out_q <= onehot(idx_q);
        div_q <= '0;
      end else if (bus.load) begin
        idx_q <= bus.sel;
        out_q <= onehot(bus.sel);
        div_q <= '0;
      end else if (div_q == DIV_MAX) begin
        div_q  <= '0;
        idx_q  <= idx_step;
        out_q  <= onehot(idx_step);
        wrap_q <= at_edge;
      end else begin
        div_q <= div_q + 8'd1;
      end
    end
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule
